// File: rtl/sub_serial.sv
// Bit-serial unsigned subtractor: one difference bit per clock, LSB first.
// Optional input descrambling is enabled by defining SUB_SERIAL_DESCRAMBLE_EN (WIDTH=8 only).
module sub_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2,
        BAD  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg, a_nxt, b_nxt, out_nxt;
    logic [WIDTH-1:0] a_cap, b_cap;
    logic [CW-1:0]    count, count_nxt;
    logic             borrow_nxt, busy_nxt, done_nxt;
    logic             run_q;
    logic             diff;

`ifdef SUB_SERIAL_DESCRAMBLE_EN
    localparam logic [WIDTH-1:0] A_MASK = WIDTH'(8'hE8);
    localparam logic [WIDTH-1:0] B_MASK = WIDTH'(8'hCC);
    assign a_cap = a ^ A_MASK;
    assign b_cap = b ^ B_MASK;
`else
    assign a_cap = a;
    assign b_cap = b;
`endif

    // Low for the first edge after reset release, so that edge is always an IDLE cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) run_q <= 1'b0;
        else      run_q <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            out    <= '0;
            borrow <= 1'b0;
            count  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            a_reg  <= a_nxt;
            b_reg  <= b_nxt;
            out    <= out_nxt;
            borrow <= borrow_nxt;
            count  <= count_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        a_nxt      = a_reg;
        b_nxt      = b_reg;
        out_nxt    = out;
        borrow_nxt = borrow;
        count_nxt  = count;
        diff       = a_reg[0] ^ b_reg[0] ^ borrow;

        case (state)
            IDLE, DONE: begin
                if (en && run_q) begin
                    a_nxt      = a_cap;
                    b_nxt      = b_cap;
                    out_nxt    = '0;
                    borrow_nxt = 1'b0;
                    count_nxt  = '0;
                    state_nxt  = SUB;
                end
            end
            SUB: begin
                out_nxt    = {diff, out[WIDTH-1:1]};
                borrow_nxt = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & borrow);
                a_nxt      = a_reg >> 1;
                b_nxt      = b_reg >> 1;
                // Counter stops at its last value instead of wrapping on the final bit.
                if (count == CW'(WIDTH - 1)) state_nxt = DONE;
                else                         count_nxt = count + CW'(1);
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt == SUB);
        done_nxt = (state_nxt == DONE);
    end

endmodule

// File: tb/tb_sub_serial.sv
// Bench for sub_serial: vector table, back-to-back, reset abort and randomized operands.
// Follows SUB_SERIAL_DESCRAMBLE_EN so operands are pre-scrambled when the option is built in.
module tb_sub_serial;

    localparam int unsigned W = 8;
`ifdef SUB_SERIAL_DESCRAMBLE_EN
    localparam logic [7:0] SCR_A = 8'hE8;
    localparam logic [7:0] SCR_B = 8'hCC;
`else
    localparam logic [7:0] SCR_A = 8'h00;
    localparam logic [7:0] SCR_B = 8'h00;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic [W-1:0] a   = '0;
    logic [W-1:0] b   = '0;
    logic [W-1:0] out;
    logic         borrow, busy, done;

    int checks   = 0;
    int failures = 0;

    sub_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .a     (a),
        .b     (b),
        .out   (out),
        .borrow(borrow),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_out;
        logic       exp_borrow;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start one operation with the given raw port values, wait (bounded) for done.
    task automatic run_op(input logic [7:0] ra, input logic [7:0] rb, input bit noisy,
                          output int busy_cycles, output bit overlap, output bit timeout);
        busy_cycles = 0;
        overlap     = 1'b0;
        @(negedge clk);
        a  = ra;
        b  = rb;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        timeout = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (busy && done) overlap = 1'b1;
            if (done) begin
                timeout = 1'b0;
                break;
            end
            if (busy) busy_cycles++;
            if (noisy) begin
                a  = W'($urandom);
                b  = W'($urandom);
                en = 1'($urandom);
            end
            @(negedge clk);
        end
        en = 1'b0;
    endtask

    vec_t       vecs[10];
    int         bc;
    bit         ov, to;
    logic [7:0] ra, rb, held_out;
    logic [7:0] got_out[$];
    logic       got_bor[$];
    int         idle_gaps, busy_total;

    initial begin
        vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        vecs[2] = '{8'hAA, 8'hAA, 8'h00, 1'b0};
        vecs[3] = '{8'h10, 8'h01, 8'h0F, 1'b0};
        vecs[4] = '{8'h01, 8'h02, 8'hFF, 1'b1};
        vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[6] = '{8'h00, 8'hFF, 8'h01, 1'b1};
        vecs[7] = '{8'h80, 8'h7F, 8'h01, 1'b0};
        vecs[8] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
        vecs[9] = '{8'hFF, 8'hFF, 8'h00, 1'b0};

        // Reset state while the clock runs with a start request pending.
        en = 1'b1;
        a  = 8'h33;
        b  = 8'h11;
        #22;
        check("reset_out",    32'(out),    32'h0);
        check("reset_borrow", 32'(borrow), 32'h0);
        check("reset_busy",   32'(busy),   32'h0);
        check("reset_done",   32'(done),   32'h0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_hold_busy", 32'(busy), 32'h0);

        // Vector table.
        foreach (vecs[i]) begin
            run_op(vecs[i].a ^ SCR_A, vecs[i].b ^ SCR_B, 1'b0, bc, ov, to);
            check($sformatf("vec%0d_timeout", i), 32'(to), 32'h0);
            check($sformatf("vec%0d_busy_len", i), 32'(bc), 32'd8);
            check($sformatf("vec%0d_overlap", i), 32'(ov), 32'h0);
            check($sformatf("vec%0d_out", i), 32'(out), 32'(vecs[i].exp_out));
            check($sformatf("vec%0d_borrow", i), 32'(borrow), 32'(vecs[i].exp_borrow));
            held_out = out;
            a = ~a;
            b = ~b;
            repeat (2) @(negedge clk);
            check($sformatf("vec%0d_done_hold", i), 32'(done), 32'h1);
            check($sformatf("vec%0d_out_hold", i), 32'(out), 32'(held_out));
        end

        // Back-to-back with en held high: 10-01 then 01-02.
        @(negedge clk);
        a  = 8'h10 ^ SCR_A;
        b  = 8'h01 ^ SCR_B;
        en = 1'b1;
        @(negedge clk);
        a  = 8'h01 ^ SCR_A;
        b  = 8'h02 ^ SCR_B;
        idle_gaps  = 0;
        busy_total = 0;
        got_out.delete();
        got_bor.delete();
        for (int i = 0; i < 60; i++) begin
            if (!busy && !done) idle_gaps++;
            if (busy) busy_total++;
            if (done) begin
                got_out.push_back(out);
                got_bor.push_back(borrow);
                if (got_out.size() == 2) break;
            end
            @(negedge clk);
        end
        en = 1'b0;
        check("b2b_done_count", 32'(got_out.size()), 32'd2);
        check("b2b_idle_gaps",  32'(idle_gaps), 32'd0);
        check("b2b_busy_total", 32'(busy_total), 32'd16);
        if (got_out.size() == 2) begin
            check("b2b_out0", 32'(got_out[0]), 32'h0F);
            check("b2b_bor0", 32'(got_bor[0]), 32'h0);
            check("b2b_out1", 32'(got_out[1]), 32'hFF);
            check("b2b_bor1", 32'(got_bor[1]), 32'h1);
        end

        // Reset abort after the 4th SUB cycle.
        @(negedge clk);
        a  = 8'hAA ^ SCR_A;
        b  = 8'h55 ^ SCR_B;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("abort_out",    32'(out),    32'h0);
        check("abort_borrow", 32'(borrow), 32'h0);
        check("abort_busy",   32'(busy),   32'h0);
        check("abort_done",   32'(done),   32'h0);
        repeat (2) @(negedge clk);
        a   = 8'h07 ^ SCR_A;
        b   = 8'h07 ^ SCR_B;
        en  = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("release_first_edge_idle", 32'(busy), 32'h0);
        @(negedge clk);
        check("release_second_edge_start", 32'(busy), 32'h1);
        en = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check("release_timeout", 32'(to), 32'h0);
        check("release_out",    32'(out),    32'h00);
        check("release_borrow", 32'(borrow), 32'h0);

        // Randomized operands, with noise on a/b/en during SUB on half the runs.
        for (int n = 0; n < 40; n++) begin
            logic [7:0] ea, eb;
            ra = 8'($urandom);
            rb = 8'($urandom);
            ea = ra ^ SCR_A;
            eb = rb ^ SCR_B;
            run_op(ra, rb, n[0], bc, ov, to);
            check($sformatf("rnd%0d_timeout", n), 32'(to), 32'h0);
            check($sformatf("rnd%0d_busy_len", n), 32'(bc), 32'd8);
            check($sformatf("rnd%0d_overlap", n), 32'(ov), 32'h0);
            check($sformatf("rnd%0d_out", n), 32'(out), 32'(8'(ea - eb)));
            check($sformatf("rnd%0d_borrow", n), 32'(borrow), 32'(ea < eb));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
